// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer on the peripheral bus: prescaler, edge/center counting, shadowed TOP/compares, sticky period flag.
// Optional macro PWM_IRQ_EN adds a registered period interrupt on pwm_irq.
module pwm_timer_multi #(
    parameter logic [3:0] ID             = 4'h0,
    parameter int         OUTPUTS        = 4,
    parameter int         WIDTH          = 16,
    parameter int         PRESCALE_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                peripheralEnable,
    input  logic                peripheralBus_we,
    input  logic                peripheralBus_oe,
    output logic                peripheralBus_busy,
    input  logic [15:0]         peripheralBus_address,
    input  logic [3:0]          peripheralBus_byteSelect,
    output logic [31:0]         peripheralBus_dataRead,
    input  logic [31:0]         peripheralBus_dataWrite,
    output logic                requestOutput,
    output logic [OUTPUTS-1:0]  pwm_en,
    output logic [OUTPUTS-1:0]  pwm_out,
    output logic                pwm_irq
);

    localparam logic [11:0] ADDR_CONFIG   = 12'h000;
    localparam logic [11:0] ADDR_PRESCALE = 12'h004;
    localparam logic [11:0] ADDR_TOP      = 12'h008;
    localparam logic [11:0] ADDR_STATUS   = 12'h00C;

    function automatic logic [11:0] cmp_addr(input int i);
        return 12'(16 + 4 * i);
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] lanes);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (lanes[b]) res[8*b +: 8] = data[8*b +: 8];
        return res;
    endfunction

    logic        sel, wr;
    logic [11:0] loc;
    logic        wr_cfg, wr_pre, wr_top, wr_stat;

    logic                      cfg_en, cfg_mode, cfg_irq;
    logic [OUTPUTS-1:0]        cfg_oe;
    logic [PRESCALE_WIDTH-1:0] prescale, pre;
    logic [WIDTH-1:0]          top_pend, top_act, cnt;
    logic [WIDTH-1:0]          cmp_pend [OUTPUTS];
    logic [WIDTH-1:0]          cmp_act  [OUTPUTS];
    logic                      dir_down, mode_act, period_flag;

    logic [31:0]      cfg_word, cfg_merged;
    logic             tick, boundary, dir_next;
    logic [WIDTH-1:0] cnt_next;
    logic             unused_bits;

    assign sel     = peripheralEnable && (peripheralBus_address[15:12] == ID);
    assign loc     = peripheralBus_address[11:0];
    assign wr      = sel && peripheralBus_we;
    assign wr_cfg  = wr && (loc == ADDR_CONFIG);
    assign wr_pre  = wr && (loc == ADDR_PRESCALE);
    assign wr_top  = wr && (loc == ADDR_TOP);
    assign wr_stat = wr && (loc == ADDR_STATUS);

    assign peripheralBus_busy = 1'b0;
    assign pwm_en             = cfg_oe;
    assign unused_bits        = ^cfg_merged;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cfg_word              = '0;
        cfg_word[0]           = cfg_en;
        cfg_word[1]           = cfg_mode;
        cfg_word[2]           = cfg_irq;
        cfg_word[8 +: OUTPUTS] = cfg_oe;
        cfg_merged            = merge_lanes(cfg_word, peripheralBus_dataWrite, peripheralBus_byteSelect);
    end

    // Center mode turns around on the tick that leaves TOP or leaves 0, so both extremes last one tick.
    always_comb begin
        tick     = cfg_en && (pre == prescale);
        boundary = 1'b0;
        cnt_next = cnt;
        dir_next = dir_down;
        if (tick) begin
            if (top_act == '0) begin
                boundary = 1'b1;
                cnt_next = '0;
                dir_next = 1'b0;
            end else if (!mode_act) begin
                boundary = (cnt == top_act);
                cnt_next = boundary ? '0 : cnt + WIDTH'(1);
            end else if (!dir_down) begin
                if (cnt == top_act) begin
                    dir_next = 1'b1;
                    cnt_next = cnt - WIDTH'(1);
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
            end else if (cnt == '0) begin
                boundary = 1'b1;
                dir_next = 1'b0;
                cnt_next = (top_pend == '0) ? '0 : WIDTH'(1);
            end else begin
                cnt_next = cnt - WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_en      <= 1'b0;
            cfg_mode    <= 1'b0;
            cfg_oe      <= '0;
            prescale    <= '0;
            top_pend    <= '1;
            top_act     <= '1;
            cnt         <= '0;
            pre         <= '0;
            dir_down    <= 1'b0;
            mode_act    <= 1'b0;
            period_flag <= 1'b0;
            pwm_out     <= '0;
            // NOTE: the compare arrays are small register banks with defined reset values, not RAM.
            for (int i = 0; i < OUTPUTS; i++) begin
                cmp_pend[i] <= '0;
                cmp_act[i]  <= '0;
            end
`ifdef PWM_IRQ_EN
            cfg_irq     <= 1'b0;
            pwm_irq     <= 1'b0;
`endif
        end else begin
            if (wr_cfg) begin
                cfg_en   <= cfg_merged[0];
                cfg_mode <= cfg_merged[1];
                cfg_oe   <= cfg_merged[8 +: OUTPUTS];
`ifdef PWM_IRQ_EN
                cfg_irq  <= cfg_merged[2];
`endif
            end
            if (wr_pre)
                prescale <= PRESCALE_WIDTH'(merge_lanes(32'(prescale), peripheralBus_dataWrite,
                                                        peripheralBus_byteSelect));
            if (wr_top)
                top_pend <= WIDTH'(merge_lanes(32'(top_pend), peripheralBus_dataWrite,
                                               peripheralBus_byteSelect));
            for (int i = 0; i < OUTPUTS; i++)
                if (wr && (loc == cmp_addr(i)))
                    cmp_pend[i] <= WIDTH'(merge_lanes(32'(cmp_pend[i]), peripheralBus_dataWrite,
                                                      peripheralBus_byteSelect));

            // Stopped: counter parked and shadows follow pending; mode is captured as the enable rises.
            if (!cfg_en) begin
                pre      <= '0;
                cnt      <= '0;
                dir_down <= 1'b0;
                mode_act <= wr_cfg ? cfg_merged[1] : cfg_mode;
                top_act  <= top_pend;
                for (int i = 0; i < OUTPUTS; i++) cmp_act[i] <= cmp_pend[i];
            end else begin
                pre      <= tick ? '0 : pre + PRESCALE_WIDTH'(1);
                cnt      <= cnt_next;
                dir_down <= dir_next;
                if (boundary) begin
                    top_act <= top_pend;
                    for (int i = 0; i < OUTPUTS; i++) cmp_act[i] <= cmp_pend[i];
                end
            end

            if (boundary)
                period_flag <= 1'b1;
            else if (wr_stat && peripheralBus_byteSelect[3] && peripheralBus_dataWrite[31])
                period_flag <= 1'b0;

            for (int i = 0; i < OUTPUTS; i++)
                pwm_out[i] <= cfg_oe[i] && (cnt < cmp_act[i]);
`ifdef PWM_IRQ_EN
            pwm_irq <= cfg_irq && period_flag;
`endif
        end
    end

`ifndef PWM_IRQ_EN
    assign cfg_irq = 1'b0;
    assign pwm_irq = 1'b0;
`endif

    always_comb begin
        peripheralBus_dataRead = '0;
        requestOutput          = 1'b0;
        if (sel && peripheralBus_oe) begin
            if (loc == ADDR_CONFIG) begin
                requestOutput          = 1'b1;
                peripheralBus_dataRead = cfg_word;
            end else if (loc == ADDR_PRESCALE) begin
                requestOutput          = 1'b1;
                peripheralBus_dataRead = 32'(prescale);
            end else if (loc == ADDR_TOP) begin
                requestOutput          = 1'b1;
                peripheralBus_dataRead = 32'(top_pend);
            end else if (loc == ADDR_STATUS) begin
                requestOutput                       = 1'b1;
                peripheralBus_dataRead[WIDTH-1:0]   = cnt;
                peripheralBus_dataRead[16 +: OUTPUTS] = pwm_out;
                peripheralBus_dataRead[24]          = dir_down;
                peripheralBus_dataRead[31]          = period_flag;
            end
            for (int i = 0; i < OUTPUTS; i++) begin
                if (loc == cmp_addr(i)) begin
                    requestOutput          = 1'b1;
                    peripheralBus_dataRead = 32'(cmp_pend[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Self-checking bench for pwm_timer_multi: register vector table, then scoreboarded waveform runs
// in edge mode, center mode, reset mid-run and TOP=0 period-flag handling.
module tb_pwm_timer_multi;

    localparam int OUTPUTS = 4;
`ifdef PWM_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               pe, we, oe;
    logic               busy;
    logic [15:0]        addr;
    logic [3:0]         bsel;
    logic [31:0]        rdata, wdata;
    logic               req;
    logic [OUTPUTS-1:0] pwm_en, pwm_out;
    logic               pwm_irq;

    pwm_timer_multi #(.ID(4'h0), .OUTPUTS(OUTPUTS), .WIDTH(16), .PRESCALE_WIDTH(16)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .peripheralEnable         (pe),
        .peripheralBus_we         (we),
        .peripheralBus_oe         (oe),
        .peripheralBus_busy       (busy),
        .peripheralBus_address    (addr),
        .peripheralBus_byteSelect (bsel),
        .peripheralBus_dataRead   (rdata),
        .peripheralBus_dataWrite  (wdata),
        .requestOutput            (req),
        .pwm_en                   (pwm_en),
        .pwm_out                  (pwm_out),
        .pwm_irq                  (pwm_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        bit   clear;
        logic exp_flag;
    } flag_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        pe = 1'b1; we = 1'b1; addr = {4'h0, a}; wdata = d; bsel = be;
        tick();
        pe = 1'b0; we = 1'b0; bsel = 4'h0; wdata = '0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic r);
        pe = 1'b1; oe = 1'b1; addr = a;
        #1;
        d = rdata; r = req;
        pe = 1'b0; oe = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Expected center-mode count after t ticks with TOP=4: 0,1,2,3,4,3,2,1 repeating.
    function automatic int center_cnt(input int t);
        int m;
        m = t % 8;
        return (m <= 4) ? m : 8 - m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reg_vec_t    regs[11];
        flag_vec_t   flags[12];
        logic [31:0] d, exp;
        logic        r, prev_flag;
        int          k, cmp_eff, t, highs;

        regs[0]  = '{12'h000, 32'h0000_FF06, 4'b0011, 32'h0000_0F02 | (IRQ_BUILT ? 32'h4 : 32'h0)};
        regs[1]  = '{12'h000, 32'hFFFF_0001, 4'b1100, 32'h0000_0F02 | (IRQ_BUILT ? 32'h4 : 32'h0)};
        regs[2]  = '{12'h000, 32'h0000_0000, 4'b1111, 32'h0000_0000};
        regs[3]  = '{12'h004, 32'h0001_2345, 4'b1111, 32'h0000_2345};
        regs[4]  = '{12'h004, 32'h0000_ABCD, 4'b0001, 32'h0000_23CD};
        regs[5]  = '{12'h008, 32'h0000_0009, 4'b0001, 32'h0000_FF09};
        regs[6]  = '{12'h008, 32'h1234_5678, 4'b1111, 32'h0000_5678};
        regs[7]  = '{12'h010, 32'h0000_0003, 4'b1111, 32'h0000_0003};
        regs[8]  = '{12'h01C, 32'hFFFF_1234, 4'b0011, 32'h0000_1234};
        regs[9]  = '{12'h018, 32'h0000_00AA, 4'b0010, 32'h0000_0000};
        regs[10] = '{12'h00C, 32'h8000_0000, 4'b1000, 32'h0000_0000};

        // TOP=0, P=2: a tick every 3 clocks, first on clock 3 after enable.
        flags[0]  = '{1'b0, 1'b0};
        flags[1]  = '{1'b0, 1'b0};
        flags[2]  = '{1'b0, 1'b1};
        flags[3]  = '{1'b1, 1'b0};
        flags[4]  = '{1'b0, 1'b0};
        flags[5]  = '{1'b0, 1'b1};
        flags[6]  = '{1'b0, 1'b1};
        flags[7]  = '{1'b0, 1'b1};
        flags[8]  = '{1'b1, 1'b1};
        flags[9]  = '{1'b1, 1'b0};
        flags[10] = '{1'b0, 1'b0};
        flags[11] = '{1'b0, 1'b1};

        pe = 1'b0; we = 1'b0; oe = 1'b0; addr = '0; bsel = '0; wdata = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset pwm_out", 32'(pwm_out), 32'h0);
        check("reset pwm_en", 32'(pwm_en), 32'h0);
        check("reset pwm_irq", 32'(pwm_irq), 32'h0);
        check("busy", 32'(busy), 32'h0);
        check("idle requestOutput", 32'(req), 32'h0);
        check("idle dataRead", rdata, 32'h0);
        rd(16'h0000, d, r); check("reset CONFIG", d, 32'h0);
        rd(16'h0008, d, r); check("reset TOP", d, 32'h0000_FFFF);
        rd(16'h000C, d, r); check("reset STATUS", d, 32'h0);
        rd(16'h0010, d, r); check("reset CMP0", d, 32'h0); check("CMP0 responds", 32'(r), 32'h1);
        rd(16'h0020, d, r); check("unmapped req", 32'(r), 32'h0); check("unmapped data", d, 32'h0);
        rd(16'h0002, d, r); check("misaligned req", 32'(r), 32'h0);
        rd(16'h1000, d, r); check("other ID req", 32'(r), 32'h0);

        // Register write/readback with byte lanes
        for (int i = 0; i < 11; i++) begin
            wr(regs[i].a, regs[i].d, regs[i].be);
            rd({4'h0, regs[i].a}, d, r);
            check($sformatf("reg vec %0d data", i), d, regs[i].exp);
            check($sformatf("reg vec %0d req", i), 32'(r), 32'h1);
        end

        // Edge mode P=0, TOP=9, CMP0 changed mid-period three times
        do_reset();
        wr(12'h000, 32'h0000_0100, 4'hF);
        wr(12'h004, 32'h0, 4'hF);
        wr(12'h008, 32'd9, 4'hF);
        wr(12'h010, 32'd3, 4'hF);
        wr(12'h000, 32'h0000_0101, 4'hF);
        check("edge pwm_en", 32'(pwm_en), 32'h1);
        highs = 0;
        for (k = 1; k <= 70; k++) begin
            if (k == 26)      wr(12'h010, 32'd7, 4'hF);
            else if (k == 45) wr(12'h010, 32'd0, 4'hF);
            else if (k == 55) wr(12'h010, 32'd10, 4'hF);
            else              tick();
            cmp_eff = (k >= 61) ? 10 : (k >= 51) ? 0 : (k >= 31) ? 7 : 3;
            exp = 32'(k % 10);
            if (((k - 1) % 10) < cmp_eff) exp = exp | 32'h0001_0000;
            if (k >= 10) exp = exp | 32'h8000_0000;
            exp_q.push_back(exp);
            rd(16'h000C, d, r);
            check($sformatf("edge STATUS k=%0d", k), d, exp_q.pop_front());
            check($sformatf("edge pwm_out k=%0d", k), 32'(pwm_out), (exp >> 16) & 32'hF);
            if (k <= 20 && pwm_out[0]) highs++;
        end
        check("edge duty 6 of 20", 32'(highs), 32'd6);
        check("edge irq disabled", 32'(pwm_irq), 32'h0);

        // Center mode P=1, TOP=4, CMP1=2
        do_reset();
        wr(12'h004, 32'd1, 4'hF);
        wr(12'h008, 32'd4, 4'hF);
        wr(12'h014, 32'd2, 4'hF);
        wr(12'h000, 32'h0000_0203, 4'hF);
        for (k = 1; k <= 34; k++) begin
            tick();
            t = k / 2;
            exp = 32'(center_cnt(t));
            if (center_cnt((k - 1) / 2) < 2) exp = exp | 32'h0002_0000;
            if (t >= 5 && ((t % 8) >= 5 || (t % 8) == 0)) exp = exp | 32'h0100_0000;
            if (k >= 18) exp = exp | 32'h8000_0000;
            exp_q.push_back(exp);
            rd(16'h000C, d, r);
            check($sformatf("center STATUS k=%0d", k), d, exp_q.pop_front());
        end

        // Reset mid-run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst pwm_out", 32'(pwm_out), 32'h0);
        check("rst pwm_en", 32'(pwm_en), 32'h0);
        check("rst pwm_irq", 32'(pwm_irq), 32'h0);
        rd(16'h0000, d, r); check("rst CONFIG", d, 32'h0);
        rd(16'h0004, d, r); check("rst PRESCALE", d, 32'h0);
        rd(16'h0008, d, r); check("rst TOP", d, 32'h0000_FFFF);
        rd(16'h0014, d, r); check("rst CMP1", d, 32'h0);
        rd(16'h000C, d, r); check("rst STATUS", d, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        rd(16'h000C, d, r); check("rst counter stopped", d, 32'h0);

        // TOP=0, P=2, period flag set/clear with irqEnable set
        wr(12'h004, 32'd2, 4'hF);
        wr(12'h008, 32'd0, 4'hF);
        wr(12'h000, 32'h0000_0005, 4'hF);
        prev_flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (flags[i].clear) wr(12'h00C, 32'h8000_0000, 4'b1000);
            else                tick();
            exp_q.push_back({flags[i].exp_flag, 31'h0});
            rd(16'h000C, d, r);
            check($sformatf("top0 STATUS step %0d", i), d, exp_q.pop_front());
            check($sformatf("top0 irq step %0d", i), 32'(pwm_irq), 32'(IRQ_BUILT && prev_flag));
            prev_flag = flags[i].exp_flag;
        end

        if (exp_q.size() != 0) $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_timer_multi.md
# pwm_timer_multi

Parametrised multi-channel PWM peripheral on the peripheral bus, the next generation of our single-mode PWM device. Adds a programmable period (TOP) with a linear prescaler, edge- or center-aligned counting, double-buffered compare/TOP values that update only at period boundaries, and a sticky period-end flag. Sits behind the peripheral bus decoder like every other device and drives `pwm_en`/`pwm_out` to the pin mux.

## Interface
- `ID`, 4'h0: device ID; the device is selected when `peripheralEnable` is high and `peripheralBus_address[15:12]==ID`. Local address = `address[11:0]`.
- `OUTPUTS`, 4: channel count, 1..8.
- `WIDTH`, 16: counter/compare/TOP width, 2..16.
- `PRESCALE_WIDTH`, 16: prescaler width, 1..16.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `peripheralEnable` input 1: bus cycle targets the peripheral space.
- `peripheralBus_we` input 1: write strobe.
- `peripheralBus_oe` input 1: read strobe.
- `peripheralBus_busy` output 1: constant 0.
- `peripheralBus_address` input 16: byte address.
- `peripheralBus_byteSelect` input 4: byte lanes for writes.
- `peripheralBus_dataRead` output 32: read data; 0 when not responding.
- `peripheralBus_dataWrite` input 32: write data.
- `requestOutput` output 1: high when this device drives `dataRead`.
- `pwm_en` output OUTPUTS: the per-channel output enables.
- `pwm_out` output OUTPUTS: PWM waveforms.
- `pwm_irq` output 1: period interrupt (see Configuration).

## Operation
- Registers (word-aligned, unlisted addresses do not respond):
  - 0x000 CONFIG: b0 counterEnable, b1 mode (0 edge, 1 center), b2 irqEnable, b[8+:OUTPUTS] outputEnable. Reset 0.
  - 0x004 PRESCALE: P, PRESCALE_WIDTH bits. Reset 0.
  - 0x008 TOP: pending TOP, WIDTH bits. Reset all ones.
  - 0x00C STATUS (read): b[WIDTH-1:0] counter, b[16+:OUTPUTS] pwm_out, b24 direction (1 = down), b31 periodFlag. Writing 1 to b31 (byteSelect[3]) clears the flag.
  - 0x010+4*i CMPi: pending compare for channel i, WIDTH bits. Reset 0.
- Writes occur on the `clk` edge when selected and `we` is high, per byteSelect lane; unused bits read 0.
- Reads: `dataRead`/`requestOutput` combinational from the address while selected and `oe` is high. Reads of TOP/CMPi return the pending value.
- Prescaler: `pre` counts 0..P; tick when `pre==P`, so the counter advances every P+1 clocks.
- Edge mode: on tick, `cnt` = (`cnt==TOP`) ? 0 : `cnt`+1. Boundary = tick with `cnt==TOP`. Period = (TOP+1)(P+1) clocks.
- Center mode: counts up to TOP, then down to 0. Direction flips on the tick where `cnt` reaches TOP going up or 0 going down. Boundary = tick with `cnt==0` while going down. Period = 2·TOP·(P+1) clocks.
- TOP==0 in either mode: `cnt` stays 0 and every tick is a boundary.
- Shadowing: active TOP/CMPi load from pending at each boundary. While counterEnable=0 they track pending every cycle.
- Mode is latched on the counterEnable 0->1 transition. Mode writes while running take effect at the next enable.
- counterEnable=0: `pre`, `cnt` and direction are held cleared (up).
- Channel output: `pwm_out[i]` = outputEnable[i] && (`cnt` < active CMPi). CMPi=0 gives constant low; CMPi>TOP gives constant high. Disabled channels output 0.
- periodFlag: set at each boundary. If set and clear coincide, set wins.

## Timing
- All outputs reset to 0; `cnt`, `pre` and direction reset to 0/up; pending and active TOP reset to all ones; compares reset to 0.
- `pwm_out` is registered: it reflects the `cnt` and active compare of the previous cycle (1-cycle latency).
- Counter starts on the clock after the CONFIG write. The first tick occurs P+1 clocks after the enable takes effect.
- Active values load on the same edge where `cnt` wraps or turns around, so the new period uses the new values from its first count.
- `rst` mid-period aborts immediately. The next edge returns every register and output to its reset value.
- `pwm_en` = CONFIG outputEnable, combinational from the register.

## Configuration
- `PWM_IRQ_EN` defined: `pwm_irq` = irqEnable && periodFlag, registered. It stays high until the flag is cleared.
- `PWM_IRQ_EN` undefined: `pwm_irq` is tied 0 and CONFIG b2 reads 0 and is not writable. periodFlag still operates.

## Test plan
- Edge, P=0, TOP=9, CMP0=3, en0=1 -> `pwm_out[0]` is high 3 of every 10 clocks; STATUS counter cycles 0..9.
- Center, P=1, TOP=4, CMP1=2 -> period of 16 clocks; output high while `cnt`<2, symmetric around `cnt`=0; b24 toggles at 4 and 0.
- Write CMP0=7 mid-period with TOP=9 -> old duty holds until the wrap, then 7/10 from the next period. CMP0=0 gives constant 0; CMP0=10 gives constant 1.
- TOP=0 and P=2 -> `cnt` stays 0, periodFlag sets every 3 clocks. A same-cycle W1C clear leaves the flag set.
- `PWM_IRQ_EN` with irqEnable=1 -> `pwm_irq` rises 1 clock after the boundary. A W1C to b31 drops it; without the macro it stays 0.
- Assert `rst` mid-run -> next clock all outputs are 0, TOP reads 0xFFFF, CONFIG reads 0, and the counter is stopped.
